// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int PORT_LOADER = 0;
  localparam int PORT_CORE   = 1;
  localparam int WAIT_CNT_W  = 4;

endpackage

// File: rtl/sram_arb_select.sv
// Two-way request selector: turns the request vector into a one-hot grant.
// Latency: combinational grant; round-robin pointer (if built in) updates on the grant edge.
// Backpressure: a losing request is simply not granted and stays pending at its requester.
// Optional feature macro: SRAM_ARB_ROUND_ROBIN_EN (round-robin instead of fixed p0 > p1).
// Ports: req[1:0] level requests, grant[1:0] one-hot (or zero) grant;
//        with the macro defined also clk, reset and take (grant accepted this cycle).
import sram_arb_pkg::*;

module sram_arb_select (
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  input  logic       clk,
  input  logic       reset,
  input  logic       take,
`endif
  input  logic [1:0] req,
  output logic [1:0] grant
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // Pointer holds the port granted most recently; reset as if the core went last
  // so the loader wins the first contested grant.
  logic last_core;

  always_comb begin
    grant = req;
    if (req[PORT_LOADER] && req[PORT_CORE]) begin
      grant = last_core ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_core <= 1'b1;
    end else if (take && (req != 2'b00)) begin
      last_core <= grant[PORT_CORE];
    end
  end
`else
  // Fixed priority: the loader always beats the core.
  always_comb begin
    grant              = 2'b00;
    grant[PORT_LOADER] = req[PORT_LOADER];
    grant[PORT_CORE]   = req[PORT_CORE] & ~req[PORT_LOADER];
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and access sequencer for the async 128Kx16 SRAM wrapper.
// Latency: request seen in IDLE at cycle n -> ack at n+2+WAIT_CYCLES; one access per 3+WAIT_CYCLES.
// Backpressure: level req held until the one-cycle ack; requests outside IDLE wait for IDLE.
// Optional feature macro: SRAM_ARB_ROUND_ROBIN_EN (round-robin arbitration).
// Ports: clk, reset (sync, active-high); p0_*/p1_* request ports (req/we/addr/wdata in,
//        rdata/ack out); mem_wr_en/mem_addr/mem_din registered to the wrapper, mem_dout back;
//        busy high whenever the sequencer is not idle.
import sram_arb_pkg::*;

module sram_arbiter #(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ack,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ack,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_t                state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  cur_core;
  logic                  cur_we;
  logic [1:0]            grant;
  logic                  idle_state;

  assign idle_state = (state == IDLE);

  sram_arb_select u_select (
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    .clk   (clk),
    .reset (reset),
    .take  (idle_state),
`endif
    .req   ({p1_req, p0_req}),
    .grant (grant)
  );

  // Address and data are loaded on the IDLE->SETUP edge and left untouched until the
  // next grant, so the address can never move while the write strobe is up, and the
  // strobe only moves on SETUP->STROBE and STROBE->HOLD edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      cur_core  <= 1'b0;
      cur_we    <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      busy      <= 1'b0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            cur_core <= grant[PORT_CORE];
            cur_we   <= grant[PORT_CORE] ? p1_we    : p0_we;
            mem_addr <= grant[PORT_CORE] ? p1_addr  : p0_addr;
            mem_din  <= grant[PORT_CORE] ? p1_wdata : p0_wdata;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          wait_cnt  <= '0;
          mem_wr_en <= cur_we;
          state     <= STROBE;
        end
        STROBE: begin
          if (wait_cnt == LAST_CNT) begin
            // Last strobe cycle: close the strobe, capture read data, ack in HOLD.
            mem_wr_en <= 1'b0;
            state     <= HOLD;
            if (cur_core) begin
              p1_ack <= 1'b1;
              if (!cur_we) p1_rdata <= mem_dout;
            end else begin
              p0_ack <= 1'b1;
              if (!cur_we) p0_rdata <= mem_dout;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HOLD: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_wr_en <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: two instances (WAIT_CYCLES 1 and 3), a
// behavioural async SRAM per instance, and a reference model of memory contents,
// arbitration order, ack timing and held read data.
module tb_sram_arbiter;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset     [2];
  logic        p0_req    [2];
  logic        p0_we     [2];
  logic [16:0] p0_addr   [2];
  logic [15:0] p0_wdata  [2];
  logic [15:0] p0_rdata  [2];
  logic        p0_ack    [2];
  logic        p1_req    [2];
  logic        p1_we     [2];
  logic [16:0] p1_addr   [2];
  logic [15:0] p1_wdata  [2];
  logic [15:0] p1_rdata  [2];
  logic        p1_ack    [2];
  logic        mem_wr_en [2];
  logic [16:0] mem_addr  [2];
  logic [15:0] mem_din   [2];
  logic [15:0] mem_dout  [2];
  logic        busy      [2];

  sram_arbiter #(.ADDR_W(17), .DATA_W(16), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .reset(reset[0]),
    .p0_req(p0_req[0]), .p0_we(p0_we[0]), .p0_addr(p0_addr[0]), .p0_wdata(p0_wdata[0]),
    .p0_rdata(p0_rdata[0]), .p0_ack(p0_ack[0]),
    .p1_req(p1_req[0]), .p1_we(p1_we[0]), .p1_addr(p1_addr[0]), .p1_wdata(p1_wdata[0]),
    .p1_rdata(p1_rdata[0]), .p1_ack(p1_ack[0]),
    .mem_wr_en(mem_wr_en[0]), .mem_addr(mem_addr[0]), .mem_din(mem_din[0]),
    .mem_dout(mem_dout[0]), .busy(busy[0])
  );

  sram_arbiter #(.ADDR_W(17), .DATA_W(16), .WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .reset(reset[1]),
    .p0_req(p0_req[1]), .p0_we(p0_we[1]), .p0_addr(p0_addr[1]), .p0_wdata(p0_wdata[1]),
    .p0_rdata(p0_rdata[1]), .p0_ack(p0_ack[1]),
    .p1_req(p1_req[1]), .p1_we(p1_we[1]), .p1_addr(p1_addr[1]), .p1_wdata(p1_wdata[1]),
    .p1_rdata(p1_rdata[1]), .p1_ack(p1_ack[1]),
    .mem_wr_en(mem_wr_en[1]), .mem_addr(mem_addr[1]), .mem_din(mem_din[1]),
    .mem_dout(mem_dout[1]), .busy(busy[1])
  );

  function automatic logic [15:0] pat(input int i);
    logic [31:0] t;
    t = (i * 32'h9E37) ^ 32'h5A3C;
    return t[15:0];
  endfunction

  function automatic int wc(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Async SRAM model (512 words, indexed by the low address bits).
  logic [15:0] sram [2][512];
  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 512; i++) sram[k][i] = pat(i);
    mem_dout[0] = '0;
    mem_dout[1] = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (mem_wr_en[k] === 1'b1) sram[k][mem_addr[k][8:0]] = mem_din[k];
        mem_dout[k] = sram[k][mem_addr[k][8:0]];
      end
    end
  end

  // Bus-protocol watcher: the address must not move while the strobe is up or
  // on the same edge the strobe changes (edges caused by reset excepted).
  int inv_viol = 0;
  initial begin
    logic        pw [2];
    logic [16:0] pa [2];
    logic        pr [2];
    for (int k = 0; k < 2; k++) begin pw[k] = 1'b0; pa[k] = '0; pr[k] = 1'b1; end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!pr[k] && (mem_wr_en[k] || pw[k]) && (mem_addr[k] !== pa[k])) inv_viol++;
        pw[k] = mem_wr_en[k];
        pa[k] = mem_addr[k];
        pr[k] = reset[k];
      end
    end
  end

  // Reference model state.
  logic [15:0] ref_mem [2][512];
  logic [15:0] last_rd [2][2];
  logic        last    [2];

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int start; int ac0; int ac1; int n0; int n1;
    logic [15:0] rd0; logic [15:0] rd1;
    int wen; int bsy; int spur0; int spur1;
    logic [16:0] wr_addr; logic [15:0] wr_din;
    logic [16:0] setup_addr; logic [16:0] hold_addr;
  } res_t;

  function automatic int pick(input logic r0, input logic r1, input logic lst);
    if (r0 && r1) return RR ? (lst ? 0 : 1) : 0;
    return r0 ? 0 : 1;
  endfunction

  task automatic model_serve(input int k, input int p, input logic we, input logic [16:0] a,
                             input logic [15:0] d, output logic [15:0] exp_rd);
    if (we) ref_mem[k][a[8:0]] = d;
    else    last_rd[k][p] = ref_mem[k][a[8:0]];
    exp_rd  = last_rd[k][p];
    last[k] = (p == 1);
  endtask

  task automatic do_reset(input int k);
    @(posedge clk); #1;
    reset[k] = 1'b1; p0_req[k] = 1'b0; p1_req[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset[k] = 1'b0;
    last[k] = 1'b1; last_rd[k][0] = '0; last_rd[k][1] = '0;
  endtask

  // Raise the selected requests together while the DUT is idle, drop each on the edge
  // after its ack, and record what the bus and ports did over a bounded window.
  task automatic run_round(input int k, input logic r0, input logic r1,
                           input logic we0, input logic [16:0] a0, input logic [15:0] d0,
                           input logic we1, input logic [16:0] a1, input logic [15:0] d1,
                           output res_t r);
    logic [15:0] prd0, prd1;
    logic drop0, drop1;
    int win;
    r = '{default: 0};
    win = 2 * (3 + wc(k)) + 3;
    @(posedge clk); #1;
    p0_we[k] = we0; p0_addr[k] = a0; p0_wdata[k] = d0; p0_req[k] = r0;
    p1_we[k] = we1; p1_addr[k] = a1; p1_wdata[k] = d1; p1_req[k] = r1;
    r.start = cyc;
    prd0 = p0_rdata[k]; prd1 = p1_rdata[k];
    for (int i = 0; i < win; i++) begin
      @(negedge clk);
      if (busy[k]) r.bsy++;
      if (mem_wr_en[k]) begin r.wen++; r.wr_addr = mem_addr[k]; r.wr_din = mem_din[k]; end
      if (cyc == r.start + 1) r.setup_addr = mem_addr[k];
      if (p0_rdata[k] !== prd0 && !p0_ack[k]) r.spur0++;
      if (p1_rdata[k] !== prd1 && !p1_ack[k]) r.spur1++;
      prd0 = p0_rdata[k]; prd1 = p1_rdata[k];
      drop0 = 1'b0; drop1 = 1'b0;
      if (p0_ack[k]) begin r.n0++; r.ac0 = cyc; r.rd0 = p0_rdata[k]; r.hold_addr = mem_addr[k]; drop0 = 1'b1; end
      if (p1_ack[k]) begin r.n1++; r.ac1 = cyc; r.rd1 = p1_rdata[k]; r.hold_addr = mem_addr[k]; drop1 = 1'b1; end
      @(posedge clk); #1;
      if (drop0) p0_req[k] = 1'b0;
      if (drop1) p1_req[k] = 1'b0;
    end
    p0_req[k] = 1'b0; p1_req[k] = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(0);
    do_reset(1);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++; if (busy[k] !== 1'b0) begin fails++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy[k]); end
      checks++; if (mem_wr_en[k] !== 1'b0) begin fails++; $display("FAIL reset_wr_en[%0d]: got %b expected 0", k, mem_wr_en[k]); end
      checks++; if (mem_addr[k] !== 17'h0) begin fails++; $display("FAIL reset_addr[%0d]: got %h expected 0", k, mem_addr[k]); end
      checks++; if (mem_din[k] !== 16'h0) begin fails++; $display("FAIL reset_din[%0d]: got %h expected 0", k, mem_din[k]); end
      checks++; if ({p0_ack[k], p1_ack[k]} !== 2'b00) begin fails++; $display("FAIL reset_ack[%0d]: got %b%b expected 00", k, p0_ack[k], p1_ack[k]); end
      checks++; if ({p0_rdata[k], p1_rdata[k]} !== 32'h0) begin fails++; $display("FAIL reset_rdata[%0d]: got %h/%h expected 0", k, p0_rdata[k], p1_rdata[k]); end
    end
  endtask

  task automatic test_read_p1;
    res_t r; logic [15:0] e;
    run_round(0, 1'b1, 1'b0, 1'b1, 17'h01234, 16'hBEEF, 1'b0, 17'h0, 16'h0, r);
    model_serve(0, 0, 1'b1, 17'h01234, 16'hBEEF, e);
    run_round(0, 1'b0, 1'b1, 1'b0, 17'h0, 16'h0, 1'b0, 17'h01234, 16'h0, r);
    model_serve(0, 1, 1'b0, 17'h01234, 16'h0, e);
    checks++; if (r.ac1 !== r.start + 3) begin fails++; $display("FAIL t1_latency: got cycle %0d expected %0d", r.ac1, r.start + 3); end
    checks++; if (r.rd1 !== e) begin fails++; $display("FAIL t1_rdata: got %h expected %h", r.rd1, e); end
    checks++; if (r.wen !== 0) begin fails++; $display("FAIL t1_no_write: got %0d strobe cycles expected 0", r.wen); end
    checks++; if (r.n0 !== 0 || r.n1 !== 1) begin fails++; $display("FAIL t1_acks: got p0=%0d p1=%0d expected 0/1", r.n0, r.n1); end
    checks++; if (r.bsy !== 3) begin fails++; $display("FAIL t1_busy: got %0d cycles expected 3", r.bsy); end
  endtask

  task automatic test_write_p0;
    res_t r; logic [15:0] e;
    run_round(0, 1'b1, 1'b0, 1'b1, 17'h00010, 16'hA5A5, 1'b0, 17'h0, 16'h0, r);
    model_serve(0, 0, 1'b1, 17'h00010, 16'hA5A5, e);
    checks++; if (r.wen !== 1) begin fails++; $display("FAIL t2_strobe_len: got %0d expected 1", r.wen); end
    checks++; if (r.wr_addr !== 17'h00010 || r.wr_din !== 16'hA5A5) begin fails++; $display("FAIL t2_strobe_bus: got %h/%h expected 00010/a5a5", r.wr_addr, r.wr_din); end
    checks++; if (r.setup_addr !== 17'h00010 || r.hold_addr !== 17'h00010) begin fails++; $display("FAIL t2_addr_frame: got setup %h hold %h expected 00010", r.setup_addr, r.hold_addr); end
    checks++; if (r.n0 !== 1 || r.n1 !== 0) begin fails++; $display("FAIL t2_acks: got p0=%0d p1=%0d expected 1/0", r.n0, r.n1); end
    checks++; if (r.ac0 !== r.start + 3) begin fails++; $display("FAIL t2_latency: got cycle %0d expected %0d", r.ac0, r.start + 3); end
    checks++; if (sram[0][9'h010] !== 16'hA5A5) begin fails++; $display("FAIL t2_mem: got %h expected a5a5", sram[0][9'h010]); end
  endtask

  task automatic test_rdata_isolation;
    res_t r; logic [15:0] e, d;
    run_round(0, 1'b1, 1'b0, 1'b1, 17'h00055, 16'h1111, 1'b0, 17'h0, 16'h0, r);
    model_serve(0, 0, 1'b1, 17'h00055, 16'h1111, e);
    run_round(0, 1'b0, 1'b1, 1'b0, 17'h0, 16'h0, 1'b0, 17'h00055, 16'h0, r);
    model_serve(0, 1, 1'b0, 17'h00055, 16'h0, e);
    checks++; if (r.rd1 !== 16'h1111) begin fails++; $display("FAIL t6_read: got %h expected 1111", r.rd1); end
    checks++; if (r.bsy !== 3) begin fails++; $display("FAIL t6_busy_read: got %0d expected 3", r.bsy); end
    d = 16'($urandom);
    run_round(0, 1'b1, 1'b0, 1'b1, 17'h00066, d, 1'b0, 17'h0, 16'h0, r);
    model_serve(0, 0, 1'b1, 17'h00066, d, e);
    checks++; if (r.spur1 !== 0 || p1_rdata[0] !== 16'h1111) begin fails++; $display("FAIL t6_hold: got %0d changes, rdata %h expected 0, 1111", r.spur1, p1_rdata[0]); end
    checks++; if (r.bsy !== 3 || r.n0 !== 1) begin fails++; $display("FAIL t6_busy_write: got busy %0d acks %0d expected 3/1", r.bsy, r.n0); end
  endtask

  task automatic test_arb_contention;
    int order [4]; int n; logic lst; int e;
    do_reset(0);
    for (int i = 0; i < 4; i++) order[i] = -1;
    n = 0;
    @(posedge clk); #1;
    p0_we[0] = 1'b0; p0_addr[0] = 17'h00100; p0_req[0] = 1'b1;
    p1_we[0] = 1'b0; p1_addr[0] = 17'h00101; p1_req[0] = 1'b1;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (p0_ack[0] && n < 4) begin order[n] = 0; n++; end
      if (p1_ack[0] && n < 4) begin order[n] = 1; n++; end
    end
    p0_req[0] = 1'b0; p1_req[0] = 1'b0;
    checks++; if (n !== 4) begin fails++; $display("FAIL t3_count: got %0d acks expected 4", n); end
    lst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = pick(1'b1, 1'b1, lst);
      lst = (e == 1);
      checks++; if (order[i] !== e) begin fails++; $display("FAIL t3_order[%0d]: got port %0d expected %0d", i, order[i], e); end
    end
  endtask

  task automatic test_reset_mid_access;
    int c, n, ac; logic [15:0] d, e; logic drop;
    do_reset(1);
    d = 16'($urandom);
    @(posedge clk); #1;
    p0_we[1] = 1'b1; p0_addr[1] = 17'h001F0; p0_wdata[1] = d; p0_req[1] = 1'b1; c = cyc;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset[1] = 1'b1;
    @(negedge clk);
    checks++; if (mem_wr_en[1] !== 1'b1) begin fails++; $display("FAIL t4_strobe: got %b expected 1", mem_wr_en[1]); end
    @(posedge clk); #1;
    reset[1] = 1'b0;
    @(negedge clk);
    checks++; if (mem_wr_en[1] !== 1'b0 || busy[1] !== 1'b0) begin fails++; $display("FAIL t4_abort: got wr_en %b busy %b expected 0/0", mem_wr_en[1], busy[1]); end
    checks++; if (p0_ack[1] !== 1'b0 || p1_ack[1] !== 1'b0) begin fails++; $display("FAIL t4_no_ack: got %b%b expected 00", p0_ack[1], p1_ack[1]); end
    last[1] = 1'b1; last_rd[1][0] = '0; last_rd[1][1] = '0;
    n = 0; ac = -1; drop = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (drop) p0_req[1] = 1'b0;
      drop = 1'b0;
      @(negedge clk);
      if (p0_ack[1]) begin n++; ac = cyc; drop = 1'b1; end
    end
    p0_req[1] = 1'b0;
    model_serve(1, 0, 1'b1, 17'h001F0, d, e);
    checks++; if (n !== 1) begin fails++; $display("FAIL t4_retry_acks: got %0d expected 1", n); end
    checks++; if (ac !== c + 8) begin fails++; $display("FAIL t4_retry_cycle: got %0d expected %0d", ac, c + 8); end
  endtask

  task automatic test_stream;
    int s, idx; int ac [4]; logic [15:0] rd [4]; logic [15:0] e; logic adv;
    do_reset(1);
    for (int i = 0; i < 4; i++) begin ac[i] = -100; rd[i] = 'x; end
    idx = 0; adv = 1'b0;
    @(posedge clk); #1;
    p1_we[1] = 1'b0; p1_addr[1] = 17'h0; p1_req[1] = 1'b1; s = cyc;
    for (int i = 0; i < 40 && idx < 4; i++) begin
      @(negedge clk);
      adv = 1'b0;
      if (p1_ack[1]) begin ac[idx] = cyc; rd[idx] = p1_rdata[1]; idx++; adv = 1'b1; end
      @(posedge clk); #1;
      if (adv) begin
        if (idx < 4) p1_addr[1] = 17'(idx);
        else         p1_req[1] = 1'b0;
      end
    end
    p1_req[1] = 1'b0;
    checks++; if (idx !== 4) begin fails++; $display("FAIL t5_count: got %0d expected 4", idx); end
    checks++; if (ac[0] !== s + 5) begin fails++; $display("FAIL t5_first: got %0d expected %0d", ac[0], s + 5); end
    for (int i = 0; i < 4; i++) begin
      model_serve(1, 1, 1'b0, 17'(i), 16'h0, e);
      checks++; if (rd[i] !== e) begin fails++; $display("FAIL t5_rdata[%0d]: got %h expected %h", i, rd[i], e); end
      if (i > 0) begin
        checks++; if (ac[i] - ac[i-1] !== 6) begin fails++; $display("FAIL t5_spacing[%0d]: got %0d expected 6", i, ac[i] - ac[i-1]); end
      end
    end
  endtask

  task automatic test_random(input int k, input int rounds);
    res_t r; int sel, first, w; logic r0, r1, we0, we1;
    logic [16:0] a0, a1; logic [15:0] d0, d1, e0, e1;
    int exp_ac0, exp_ac1;
    do_reset(k);
    w = wc(k);
    for (int n = 0; n < rounds; n++) begin
      sel = $urandom_range(1, 3);
      r0 = sel[0]; r1 = sel[1];
      we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
      a0 = 17'h00100 + 17'($urandom_range(0, 7));
      a1 = 17'h00100 + 17'($urandom_range(0, 7));
      d0 = 16'($urandom); d1 = 16'($urandom);
      first = pick(r0, r1, last[k]);
      run_round(k, r0, r1, we0, a0, d0, we1, a1, d1, r);
      e0 = last_rd[k][0]; e1 = last_rd[k][1];
      exp_ac0 = -1; exp_ac1 = -1;
      if (first == 0) begin
        model_serve(k, 0, we0, a0, d0, e0); exp_ac0 = r.start + 2 + w;
        if (r1) begin model_serve(k, 1, we1, a1, d1, e1); exp_ac1 = r.start + 5 + 2 * w; end
      end else begin
        model_serve(k, 1, we1, a1, d1, e1); exp_ac1 = r.start + 2 + w;
        if (r0) begin model_serve(k, 0, we0, a0, d0, e0); exp_ac0 = r.start + 5 + 2 * w; end
      end
      checks++; if (r.n0 !== int'(r0) || r.n1 !== int'(r1)) begin fails++; $display("FAIL rnd%0d_%0d_acks: got %0d/%0d expected %0d/%0d", k, n, r.n0, r.n1, r0, r1); end
      if (r0) begin
        checks++; if (r.ac0 !== exp_ac0 || r.rd0 !== e0) begin fails++; $display("FAIL rnd%0d_%0d_p0: got cycle %0d data %h expected %0d %h", k, n, r.ac0, r.rd0, exp_ac0, e0); end
      end
      if (r1) begin
        checks++; if (r.ac1 !== exp_ac1 || r.rd1 !== e1) begin fails++; $display("FAIL rnd%0d_%0d_p1: got cycle %0d data %h expected %0d %h", k, n, r.ac1, r.rd1, exp_ac1, e1); end
      end
      checks++; if (r.bsy !== (int'(r0) + int'(r1)) * (2 + w)) begin fails++; $display("FAIL rnd%0d_%0d_busy: got %0d expected %0d", k, n, r.bsy, (int'(r0) + int'(r1)) * (2 + w)); end
    end
  endtask

  task automatic test_invariants;
    checks++;
    if (inv_viol !== 0) begin fails++; $display("FAIL bus_stability: got %0d violations expected 0", inv_viol); end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1;
      p0_req[k] = 1'b0; p0_we[k] = 1'b0; p0_addr[k] = '0; p0_wdata[k] = '0;
      p1_req[k] = 1'b0; p1_we[k] = 1'b0; p1_addr[k] = '0; p1_wdata[k] = '0;
      last[k] = 1'b1; last_rd[k][0] = '0; last_rd[k][1] = '0;
      for (int i = 0; i < 512; i++) ref_mem[k][i] = pat(i);
    end
    test_reset();
    test_read_p1();
    test_write_p0();
    test_rdata_isolation();
    test_arb_contention();
    test_reset_mid_access();
    test_stream();
    test_random(0, 20);
    test_random(1, 20);
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
